// File: rtl/rr_bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding
// and an elaboration-time clog2 helper.
package rr_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_WAIT = 2'b10,
        ST_FREE = 2'b11
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Requester-side bus of the arbiter: level requests, single-master
// done/dly handshake, and the registered grant outputs.
interface rr_bus_arbiter_if
    import rr_bus_arbiter_pkg::*;
#(
    parameter int N = 4
);
    localparam int ID_W = clog2(N);

    logic [N-1:0]    req;
    logic            done;
    logic            dly;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic            timeout;

    modport master (
        output req, done, dly,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done, dly,
        output gnt, gnt_id, busy, timeout
    );

endinterface

// File: rtl/rr_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req from last_id+1 with
// wrap-around and returns the first requester found.
module rr_pick
    import rr_bus_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] last_id_i,
    output logic [N-1:0]    winner_oh_o,
    output logic [ID_W-1:0] winner_id_o,
    output logic            valid_o
);

    logic [ID_W:0]   sum_s;
    logic [ID_W-1:0] idx_s;

    // Rotating priority scan; one extra bit on the sum absorbs the wrap
    always_comb begin
        winner_oh_o = '0;
        winner_id_o = '0;
        valid_o     = 1'b0;
        sum_s       = '0;
        idx_s       = '0;
        for (int i = 0; i < N; i++) begin
            sum_s = {1'b0, last_id_i} + (ID_W + 1)'(i + 1);
            if (sum_s >= (ID_W + 1)'(N)) begin
                sum_s = sum_s - (ID_W + 1)'(N);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[ID_W-1:0];
            if (!valid_o && req_i[idx_s]) begin
                valid_o            = 1'b1;
                winner_oh_o[idx_s] = 1'b1;
                winner_id_o        = idx_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: grant FSM with done/dly release handshake,
// hold-timeout watchdog and registered grant outputs.
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 64
) (
    input  logic           clk,
    input  logic           rst,
    rr_bus_arbiter_if.slave bus
);

    localparam int ID_W  = clog2(N);
    localparam int CNT_W = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1);

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [N-1:0]    pick_oh_s;
    logic [ID_W-1:0] pick_id_s;
    logic            pick_valid_s;
    logic            hold_expired_s;

    rr_pick #(.N(N)) u_pick (
        .req_i       (bus.req),
        .last_id_i   (last_id_q),
        .winner_oh_o (pick_oh_s),
        .winner_id_o (pick_id_s),
        .valid_o     (pick_valid_s)
    );

    assign hold_expired_s = (MAX_HOLD > 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));

    // Next-state logic; outputs are computed for the state being entered
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_FREE: begin
                cnt_d = '0;
                if (pick_valid_s) begin
                    state_d   = ST_BUSY;
                    gnt_d     = pick_oh_s;
                    gnt_id_d  = pick_id_s;
                    last_id_d = pick_id_s;
                end else begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end
            end
            ST_BUSY: begin
                if (bus.done && bus.dly) begin
                    state_d = ST_WAIT;
                end else if (bus.done || hold_expired_s) begin
                    // done wins over an expiring watchdog: only a forced release pulses
                    state_d   = ST_FREE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    cnt_d     = '0;
                    timeout_d = !bus.done;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!bus.dly) begin
                    state_d  = ST_FREE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    cnt_d    = '0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                cnt_d    = '0;
            end
        endcase
        busy_d = (state_d == ST_BUSY) || (state_d == ST_WAIT);
    end

    // State, watchdog counter, rotation pointer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_id_q <= ID_W'(N - 1);
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed self-checking bench for rr_bus_arbiter (N=4, MAX_HOLD=8).
module tb_rr_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_bus_arbiter_if #(.N(N)) bus_if ();

    rr_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;
    int order [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_gnt, input int e_id,
                             input logic e_busy, input logic e_to);
        check({tag, ".gnt"}, 32'(bus_if.gnt), 32'(e_gnt));
        if (e_gnt != 4'b0000) begin
            check({tag, ".gnt_id"}, 32'(bus_if.gnt_id), 32'(e_id));
        end else begin
            check({tag, ".gnt_zero"}, 32'(bus_if.gnt == 4'b0000), 32'd1);
        end
        check({tag, ".busy"}, 32'(bus_if.busy), 32'(e_busy));
        check({tag, ".timeout"}, 32'(bus_if.timeout), 32'(e_to));
    endtask

    initial begin
        rst         = 1'b1;
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b0;
        bus_if.dly  = 1'b0;
        step();
        step();
        check("reset.gnt_id", 32'(bus_if.gnt_id), 32'd0);
        check_out("reset", 4'b0000, 0, 1'b0, 1'b0);
        rst = 1'b0;

        // 1: single request, plain release, FREE then IDLE
        bus_if.req = 4'b0001;
        step();
        check_out("t1.grant", 4'b0001, 0, 1'b1, 1'b0);
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b1;
        step();
        check_out("t1.free", 4'b0000, 0, 1'b0, 1'b0);
        bus_if.done = 1'b0;
        step();
        check_out("t1.idle", 4'b0000, 0, 1'b0, 1'b0);

        // 2: all requesting, rotation 0,1,2,3,0 from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            check_out($sformatf("t2.grant%0d", k), 4'(1 << order[k]), order[k], 1'b1, 1'b0);
            step();
            step();
            check_out($sformatf("t2.hold%0d", k), 4'(1 << order[k]), order[k], 1'b1, 1'b0);
            bus_if.done = 1'b1;
            step();
            check_out($sformatf("t2.free%0d", k), 4'b0000, 0, 1'b0, 1'b0);
            bus_if.done = 1'b0;
            if (k == 4) bus_if.req = 4'b0000;
            step();
        end
        check_out("t2.idle", 4'b0000, 0, 1'b0, 1'b0);

        // 3: master 2, done with dly held five cycles through WAIT
        bus_if.req = 4'b0100;
        step();
        check_out("t3.grant", 4'b0100, 2, 1'b1, 1'b0);
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b1;
        bus_if.dly  = 1'b1;
        step();
        bus_if.done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_out($sformatf("t3.wait%0d", k), 4'b0100, 2, 1'b1, 1'b0);
            step();
        end
        check_out("t3.wait4", 4'b0100, 2, 1'b1, 1'b0);
        bus_if.dly = 1'b0;
        step();
        check_out("t3.free", 4'b0000, 0, 1'b0, 1'b0);
        step();
        check_out("t3.idle", 4'b0000, 0, 1'b0, 1'b0);

        // 4: master 1 never finishes; watchdog fires after 8 BUSY cycles
        bus_if.req = 4'b0010;
        step();
        check_out("t4.grant", 4'b0010, 1, 1'b1, 1'b0);
        bus_if.req = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            step();
        end
        check_out("t4.last_busy", 4'b0010, 1, 1'b1, 1'b0);
        step();
        check_out("t4.timeout", 4'b0000, 0, 1'b0, 1'b1);
        step();
        check_out("t4.next", 4'b0100, 2, 1'b1, 1'b0);
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b1;
        step();
        check_out("t4.free", 4'b0000, 0, 1'b0, 1'b0);
        bus_if.done = 1'b0;
        step();

        // 5a: done lands on the expiring cycle, no timeout pulse
        bus_if.req = 4'b1000;
        step();
        check_out("t5.grant", 4'b1000, 3, 1'b1, 1'b0);
        bus_if.req = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            step();
        end
        bus_if.done = 1'b1;
        step();
        check_out("t5.done_at_limit", 4'b0000, 0, 1'b0, 1'b0);
        bus_if.done = 1'b0;
        step();

        // 5b: withdrawn request does not revoke the grant
        bus_if.req = 4'b0001;
        step();
        check_out("t5b.grant", 4'b0001, 0, 1'b1, 1'b0);
        bus_if.req = 4'b0000;
        step();
        step();
        check_out("t5b.held", 4'b0001, 0, 1'b1, 1'b0);
        bus_if.done = 1'b1;
        step();
        check_out("t5b.free", 4'b0000, 0, 1'b0, 1'b0);
        bus_if.done = 1'b0;
        step();

        // 6: asynchronous reset during WAIT with master 3 granted
        bus_if.req = 4'b1000;
        step();
        check_out("t6.grant", 4'b1000, 3, 1'b1, 1'b0);
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b1;
        bus_if.dly  = 1'b1;
        step();
        bus_if.done = 1'b0;
        check_out("t6.wait", 4'b1000, 3, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("t6.async_rst", 4'b0000, 0, 1'b0, 1'b0);
        bus_if.dly = 1'b0;
        bus_if.req = 4'b1001;
        rst        = 1'b0;
        step();
        check_out("t6.first_after_rst", 4'b0001, 0, 1'b1, 1'b0);
        bus_if.req  = 4'b1000;
        bus_if.done = 1'b1;
        step();
        check_out("t6.free", 4'b0000, 0, 1'b0, 1'b0);
        bus_if.done = 1'b0;
        step();
        check_out("t6.second", 4'b1000, 3, 1'b1, 1'b0);
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        step();
        check_out("t6.idle", 4'b0000, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
Shares one bus among N requesters using round-robin arbitration.
Each grant uses the team's standard single-master handshake: the master asserts done when it finishes, and dly holds the bus while post-transfer latency drains.
A hold-timeout watchdog reclaims the bus from a master that never signals done.
Sits between the requester agents and the bus mux; its gnt vector drives the mux select.

Parameters:
N, 4, number of requesters (2..16)
MAX_HOLD, 64, max cycles a grant may stay in BUSY before forced release; 0 disables the timeout
ID_W (localparam), clog2(N), width of gnt_id

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
req  input  N  request per requester, level, held until granted
done  input  1  current master finished its transfer; sampled only in BUSY
dly  input  1  post-transfer latency pending; sampled in BUSY (with done) and in WAIT
gnt  output  N  registered one-hot grant, or all zero
gnt_id  output  ID_W  index of the granted requester; valid only while |gnt
busy  output  1  registered; high in BUSY or WAIT
timeout  output  1  registered one-cycle pulse when a grant is forcibly revoked

Behaviour:
- Reset is asynchronous, active-high. Values during and after reset:
  - state = IDLE; gnt = 0; gnt_id = 0; busy = 0; timeout = 0; hold counter = 0.
  - last_id = N-1, so requester 0 has first priority.
- State encoding: IDLE = 00, BUSY = 01, WAIT = 10, FREE = 11.
- Next-state logic is combinational; all outputs are registered from the next state (the output register is loaded with the value for the next state).
- Latency: a req sampled high at edge k in IDLE or FREE gives gnt high from edge k (it is visible in the cycle after the sampling edge).
- Winner selection: scan req starting at last_id+1 and wrapping modulo N; the first set bit wins.
  - A lone requester may win back-to-back.
  - last_id is updated to the winner when the grant is issued.
- IDLE: |req goes to BUSY with the winner; otherwise stay in IDLE.
- BUSY:
  - gnt held; the hold counter increments each cycle.
  - done=1 and dly=1 goes to WAIT.
  - done=1 and dly=0 goes to FREE.
  - done=0 and counter == MAX_HOLD-1 (MAX_HOLD > 0) goes to FREE; timeout pulses for exactly one cycle, coincident with gnt falling.
  - done=0 otherwise stays in BUSY.
  - done takes priority over the timeout when both occur in the same cycle: no pulse.
- WAIT: gnt held; counter frozen; dly=0 goes to FREE. WAIT has no timeout.
- FREE:
  - gnt = 0 for exactly one turnaround cycle; the counter clears.
  - |req goes to BUSY with a new winner; otherwise go to IDLE.
- Req changes while a grant is held are ignored; a withdrawn req does not revoke gnt.
- gnt and gnt_id change only on entry to BUSY or to FREE/IDLE. gnt is never multi-hot.
- done or dly outside its sampling state is ignored.
- An unreachable state recovers to IDLE on the next edge, with gnt = 0.
- Reset asserted mid-grant clears gnt immediately (asynchronously); no timeout pulse is generated.

Decomposition:
- Shared package: state encoding constants (IDLE/BUSY/WAIT/FREE) and a clog2 function.
- Sub-module rr_pick: purely combinational; inputs req and last_id; outputs a one-hot winner and its index.
  - Handles the rotate-and-priority-encode scan with wrap-around.
  - Reusable by other arbiters.
- The top level holds the FSM, the hold counter, last_id and the output registers.

Test Plan:
1. Reset, then req = 0001. Required: gnt = 0001 and gnt_id = 0 one cycle later. Then done = 1, dly = 0. Required: BUSY to FREE, gnt = 0000 for 1 cycle, then IDLE; busy = 0.
2. req = 1111 held constant, each master asserting done after 3 cycles. Required: grant order 0, 1, 2, 3, 0; one zero-gnt FREE cycle between consecutive grants.
3. Master 2 granted, then done = 1 with dly = 1, dly held 5 cycles. Required: gnt stays 0100 through WAIT; FREE is entered on the cycle after dly falls.
4. MAX_HOLD = 8, master 1 granted, done never asserted. Required: gnt drops after 8 BUSY cycles with timeout = 1 for one cycle; the next requester (index 2 if requesting) is granted after FREE.
5. done asserted on the exact timeout cycle. Required: normal release, timeout stays 0. Separately, the granted master drops req mid-grant. Required: gnt held until done.
6. rst pulsed while in WAIT with gnt = 1000. Required: gnt = 0 asynchronously; after release, req = 1001 grants index 0 first (last_id restored to N-1).
